// File: rtl/bin_img_packer_pkg.sv
// Shared definitions for the binary image packer.
//   state_t : packer FSM encoding (IDLE / ACTIVE / FLUSH)
//   WORD_W  : packed word width (pixels per word)
//   ADDR_W  : word address width
package bin_img_packer_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_word_fifo.sv
// Synchronous FIFO carrying packed {addr,data} words to the write port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and storage)
//   push, din  : write request and data; ignored when full unless a pop happens
//                in the same cycle (then both succeed)
//   pop        : read request; ignored when empty
//   dout       : head entry (zero after reset)
//   full/empty : occupancy status
// DEPTH must be a power of two and at least 2.
module bin_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/bin_img_packer.sv
// Packs a binary (1 bit per pixel) video stream into 16-bit words and
// presents them on a valid/ready write port with a word address.
// Ports:
//   clk, rst_n                 : pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken : frame valid, line valid, pixel strobe
//   per_img_Bit                : binary pixel
//   wr_valid/wr_ready          : output handshake
//   wr_data/wr_addr            : packed word (bit 0 = leftmost pixel), word index
//   frame_done                 : one-cycle pulse when a frame has fully drained
//   line_err/frame_err/overflow: sticky error flags, cleared at frame start
//   state_dbg                  : current FSM state
// Handshake: a word transfers on every rising clk edge where wr_valid and
// wr_ready are both 1; while wr_valid=1 and wr_ready=0, wr_data and wr_addr
// hold steady, and wr_valid never drops without a transfer.
module bin_img_packer
  import bin_img_packer_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP  = 11'd1024,
  parameter logic [9:0]  IMG_VDISP  = 10'd720,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic              per_img_Bit,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  state_t              state;
  // Input registers; all edge detection and pixel capture work on these.
  logic                vs_r, vs_rr, vs_rrr;
  logic                hr_r, hr_rr;
  logic                ce_r, bit_r;

  logic [10:0]         pix_cnt;
  logic [9:0]          line_cnt;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [WORD_W-1:0]   acc;
  logic                pend_start;

  // Staging register between the accumulator and the FIFO.
  logic                push_q;
  logic [WORD_W-1:0]   push_data;
  logic [ADDR_W-1:0]   push_addr;

  logic                vs_rise, vs_fall, line_end, pix_take;
  logic [WORD_W-1:0]   acc_next;
  logic [9:0]          lines_at_fall;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W+WORD_W-1:0] fifo_dout;

  assign vs_rise  = vs_r & ~vs_rr;
  // The falling edge is qualified one stage later than the rising edge, so a
  // one-cycle vsync drop followed by a rise reaches ACTIVE as a rise (frame
  // restart) with rise taking priority, rather than ending the frame.
  assign vs_fall  = ~vs_rr & vs_rrr;
  assign line_end = hr_rr & ~hr_r;
  assign pix_take = hr_r & ce_r;

  always_comb begin
    acc_next = acc;
    acc_next[pix_cnt[3:0]] = bit_r;
  end

  // Line end and vsync fall can coincide; count the closing line first.
  assign lines_at_fall = line_end ? (line_cnt + 10'd1) : line_cnt;

  assign wr_valid  = ~fifo_empty;
  assign fifo_pop  = wr_valid & wr_ready;
  assign wr_addr   = fifo_dout[ADDR_W+WORD_W-1:WORD_W];
  assign wr_data   = fifo_dout[WORD_W-1:0];
  assign state_dbg = state;

  bin_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (ADDR_W + WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_q),
    .din  ({push_addr, push_data}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vs_r       <= 1'b0;
      vs_rr      <= 1'b0;
      vs_rrr     <= 1'b0;
      hr_r       <= 1'b0;
      hr_rr      <= 1'b0;
      ce_r       <= 1'b0;
      bit_r      <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      addr_cnt   <= '0;
      acc        <= '0;
      pend_start <= 1'b0;
      push_q     <= 1'b0;
      push_data  <= '0;
      push_addr  <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vs_r       <= per_frame_vsync;
      vs_rr      <= vs_r;
      vs_rrr     <= vs_rr;
      hr_r       <= per_frame_href;
      hr_rr      <= hr_r;
      ce_r       <= per_frame_clken;
      bit_r      <= per_img_Bit;
      push_q     <= 1'b0;
      frame_done <= 1'b0;

      // A staged word meeting a full FIFO with no pop is lost.
      if (push_q && fifo_full && !fifo_pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (vs_rise || pend_start) begin
            state      <= ST_ACTIVE;
            pend_start <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            addr_cnt   <= '0;
            acc        <= '0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (vs_rise) begin
            // Restart mid-frame: partial word is discarded.
            frame_err <= 1'b1;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            addr_cnt  <= '0;
            acc       <= '0;
          end else begin
            if (pix_take) begin
              if (pix_cnt < IMG_HDISP) begin
                pix_cnt <= pix_cnt + 11'd1;
                if (pix_cnt[3:0] == 4'hF) begin
                  push_q    <= 1'b1;
                  push_data <= acc_next;
                  push_addr <= addr_cnt;
                  addr_cnt  <= addr_cnt + 1'b1;
                  acc       <= '0;
                end else begin
                  acc <= acc_next;
                end
              end else begin
                line_err <= 1'b1;
              end
            end
            if (line_end) begin
              line_cnt <= line_cnt + 10'd1;
              if (pix_cnt != IMG_HDISP) line_err <= 1'b1;
              // Unused upper bits of acc are already zero.
              if (pix_cnt[3:0] != 4'h0) begin
                push_q    <= 1'b1;
                push_data <= acc;
                push_addr <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
              end
              acc     <= '0;
              pix_cnt <= '0;
            end
            if (vs_fall) begin
              state <= ST_FLUSH;
              if (lines_at_fall != IMG_VDISP) frame_err <= 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          if (vs_rise) pend_start <= 1'b1;
          if (fifo_empty && !push_q) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin_img_packer.md
BIN_IMG_PACKER -- requirements
Module: bin_img_packer

Interface
REQ-001 Parameter IMG_HDISP, 11 bits, default 11'd1024, active pixels per line; SHALL be a multiple of 16.
REQ-002 Parameter IMG_VDISP, 10 bits, default 10'd720, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, output word FIFO entries (power of 2).
REQ-004 clk  in  1  pixel clock; one clock, all logic on rising edge.
REQ-005 rst_n  in  1  global reset, asynchronous assert, active-low.
REQ-006 per_frame_vsync  in  1  frame valid, high for the whole frame.
REQ-007 per_frame_href  in  1  line valid.
REQ-008 per_frame_clken  in  1  pixel strobe; a pixel is taken only when href and clken are both 1.
REQ-009 per_img_Bit  in  1  binary pixel (1 = edge).
REQ-010 wr_valid  out  1  output word available.
REQ-011 wr_ready  in  1  downstream accepts word; transfer when wr_valid and wr_ready are both 1.
REQ-012 wr_data  out  16  packed pixels, bit 0 = leftmost pixel.
REQ-013 wr_addr  out  16  word index within frame, 0 at frame start.
REQ-014 frame_done  out  1  one-cycle pulse when the frame is fully drained.
REQ-015 line_err  out  1  sticky: a line had pixel count != IMG_HDISP.
REQ-016 frame_err  out  1  sticky: line count != IMG_VDISP, or frame aborted.
REQ-017 overflow  out  1  sticky: a word was dropped because the FIFO was full.

Function
REQ-018 State machine IDLE, ACTIVE, FLUSH; reset state IDLE.
REQ-019 IDLE->ACTIVE on vsync rising edge, detected with a registered vsync; clears bit/pixel/line/address counters and all three sticky flags.
REQ-020 In IDLE, pixels are ignored.
REQ-021 ACTIVE: each taken pixel shifts into a 16-bit accumulator at position = pixel count mod 16.
REQ-022 On the 16th bit, the word is pushed into the FIFO in the following cycle, tagged with the address counter; the address then increments.
REQ-023 Latency: wr_valid rises 2 cycles after the clk edge sampling the 16th bit when the FIFO was empty.
REQ-024 Href falling edge ends a line; line counter +1.
REQ-025 If the pixel count at line end != IMG_HDISP, line_err is set.
REQ-026 A partial word at line end is zero-padded and pushed; the pixel count is then cleared.
REQ-027 Pixels beyond IMG_HDISP in one line are dropped; line_err is set.
REQ-028 ACTIVE->FLUSH on vsync falling edge.
REQ-029 At that edge, frame_err is set if the line count != IMG_VDISP.
REQ-030 A vsync rising edge while ACTIVE aborts the frame: set frame_err, discard the partial word, restart counters, stay ACTIVE.
REQ-031 FLUSH->IDLE when the FIFO is empty and no transfer is pending; frame_done pulses that same cycle.
REQ-032 A vsync rising edge in FLUSH is held pending and taken on entry to IDLE.
REQ-033 FIFO push with FIFO full and no pop in the same cycle: the word is dropped and overflow is set.
REQ-034 Push and pop in the same cycle with FIFO full: both succeed; no overflow.
REQ-035 wr_data and wr_addr are held stable while wr_valid=1 and wr_ready=0.
REQ-036 The address counter wraps at 2^16 without flagging; it never wraps at default parameters (max 46079).

Reset
REQ-037 On rst_n low, all of the following are 0: wr_valid, wr_data, wr_addr, frame_done, line_err, frame_err, overflow, all counters, and the FIFO pointers.
REQ-038 State is IDLE.
REQ-039 Reset mid-frame discards FIFO contents.
REQ-040 After release, pixels are ignored until the next vsync rising edge.

Structure
REQ-041 A shared package holds the state encoding and the constants WORD_W=16 and ADDR_W=16.
REQ-042 One sub-module, bin_word_fifo: synchronous FIFO with FIFO_DEPTH entries and full/empty outputs, carrying {addr,data}.
REQ-043 Parameters are passed through from the top level; no vendor IP is used.

Verification
REQ-044 Frame 32x2, wr_ready=1, pixel i = i[0] -> 4 words of 16'hAAAA, addrs 0..3; frame_done pulses once; no errors.
REQ-045 Line of 20 pixels, all 1, IMG_HDISP=32 -> words 16'hFFFF and 16'h000F; line_err=1.
REQ-046 wr_ready=0 over 5 full words, FIFO_DEPTH=4 -> overflow=1, only addrs 0..3 delivered after ready returns; then case REQ-034 with push/pop at full -> no new overflow.
REQ-047 Vsync low after 1 of 2 lines -> frame_err=1 and frame_done pulses after the drain.
REQ-048 Second vsync rise mid-line -> frame_err=1 and next word has wr_addr=0.
REQ-049 rst_n low mid-line -> all outputs 0 next cycle; pixels before the next vsync rise produce no words.
